// File: rtl/led_shift_decoder.sv
// Decodes a rotating one-hot LED pattern into shift direction, shift period and lock.
// Optional period-counter timeout: define LED_SHIFT_DECODER_TIMEOUT_EN.
module led_shift_decoder #(
  parameter int N_LEDS    = 4,
  parameter int NB_PERIOD = 16,
  parameter int LOCK_CNT  = 3
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic [N_LEDS-1:0]    i_led,
  output logic [NB_PERIOD-1:0] o_period,
  output logic                 o_dir,
  output logic                 o_shift,
  output logic                 o_locked,
  output logic                 o_err,
  output logic                 o_timeout
);
  localparam int            MW     = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCK} state_t;

  state_t               state, state_nx;
  logic [N_LEDS-1:0]    r_led, r_prev, rot_l, rot_r;
  logic [NB_PERIOD-1:0] cnt, period_nx;
  logic [MW-1:0]        match, match_nx;
  logic                 has_ref, ref_nx;
  logic                 dir_nx, shift_nx, locked_nx, err_nx;
  logic                 led_oh, prev_oh, hop, is_left, is_right, ev, bad, same, sat, tmo_hit;

  assign rot_l    = (r_prev << 1) | (r_prev >> (N_LEDS - 1));
  assign rot_r    = (r_prev >> 1) | (r_prev << (N_LEDS - 1));
  assign led_oh   = $onehot(r_led);
  assign prev_oh  = $onehot(r_prev);
  assign hop      = led_oh && prev_oh && (r_led != r_prev);
  assign is_left  = (r_led == rot_l);
  assign is_right = (r_led == rot_r);
  assign ev       = hop && (is_left || is_right);
  assign bad      = ((r_led != '0) && !led_oh) || (hop && !ev);
  assign sat      = &cnt;
  // The SYNC event carries no period, so the first measured event never matches.
  assign same     = has_ref && (cnt == o_period) && (is_left == o_dir);

`ifdef LED_SHIFT_DECODER_TIMEOUT_EN
  logic tmo_fire;
  assign tmo_hit = sat && (state == MEAS || state == LOCK);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    period_nx = o_period;
    dir_nx    = o_dir;
    shift_nx  = 1'b0;
    locked_nx = o_locked;
    err_nx    = 1'b0;
    match_nx  = match;
    ref_nx    = has_ref;
`ifdef LED_SHIFT_DECODER_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state)
      IDLE: if (led_oh) state_nx = SYNC;
      default: begin
        if (bad) begin
          state_nx  = IDLE;
          locked_nx = 1'b0;
          err_nx    = 1'b1;
        end else if (r_led == '0) begin
          state_nx  = IDLE;
          locked_nx = 1'b0;
        end else if (ev) begin
          shift_nx = 1'b1;
          dir_nx   = is_left;
          if (state == SYNC) begin
            state_nx = MEAS;
            match_nx = '0;
            ref_nx   = 1'b0;
          end else begin
            period_nx = cnt;
            ref_nx    = 1'b1;
            if (same) begin
              if (match != LOCK_M) match_nx = match + 1'b1;
              if (state == MEAS && match_nx == LOCK_M) begin
                state_nx  = LOCK;
                locked_nx = 1'b1;
              end
            end else begin
              match_nx = '0;
              if (state == LOCK) begin
                state_nx  = MEAS;
                locked_nx = 1'b0;
              end
            end
          end
        end
`ifdef LED_SHIFT_DECODER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nx  = IDLE;
          locked_nx = 1'b0;
          tmo_fire  = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      r_led    <= '0;
      r_prev   <= '0;
      cnt      <= '0;
      match    <= '0;
      has_ref  <= 1'b0;
      o_period <= '0;
      o_dir    <= 1'b0;
      o_shift  <= 1'b0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nx;
      r_led    <= i_led;
      r_prev   <= r_led;
      cnt      <= ev ? NB_PERIOD'(1) : (sat ? cnt : cnt + 1'b1);
      match    <= match_nx;
      has_ref  <= ref_nx;
      o_period <= period_nx;
      o_dir    <= dir_nx;
      o_shift  <= shift_nx;
      o_locked <= locked_nx;
      o_err    <= err_nx;
    end
  end

`ifdef LED_SHIFT_DECODER_TIMEOUT_EN
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) o_timeout <= 1'b0;
    else          o_timeout <= tmo_fire;
  end
`else
  assign o_timeout = 1'b0;
  // Without the timeout the saturated counter is simply held; tmo_hit stays low.
  logic unused_tmo;
  assign unused_tmo = tmo_hit;
`endif

endmodule

// File: tb/tb_led_shift_decoder.sv
// Bench for led_shift_decoder: directed scenarios then random LED traffic, every
// cycle checked against an event-level reference model.
module tb_led_shift_decoder;
  localparam int N_LEDS    = 4;
  localparam int NB_PERIOD = 16;
  localparam int LOCK_CNT  = 3;
  localparam int PMAX      = (1 << NB_PERIOD) - 1;
  localparam int NPAT      = 1 << N_LEDS;
`ifdef LED_SHIFT_DECODER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_SYNC = 1, M_MEAS = 2, M_LOCK = 3;

  logic                 clock = 1'b0;
  logic                 i_reset;
  logic [N_LEDS-1:0]    i_led;
  logic [NB_PERIOD-1:0] o_period;
  logic                 o_dir, o_shift, o_locked, o_err, o_timeout;

  int total = 0;
  int bad   = 0;
  int err_seen, tmo_seen, shift_seen;

  // reference model state
  int p, last_ev, s1, s2, m_mode, run, e_period;
  bit e_dir, e_shift, e_locked, e_err, e_tmo;

  led_shift_decoder #(.N_LEDS(N_LEDS), .NB_PERIOD(NB_PERIOD), .LOCK_CNT(LOCK_CNT)) dut (
    .clock(clock), .i_reset(i_reset), .i_led(i_led), .o_period(o_period), .o_dir(o_dir),
    .o_shift(o_shift), .o_locked(o_locked), .o_err(o_err), .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;

  function automatic int ones(input int x);
    int c = 0;
    for (int b = 0; b < N_LEDS; b++) c += (x >> b) & 1;
    return c;
  endfunction

  function automatic int rol(input int x);
    return (x * 2) % NPAT + x / (NPAT / 2);
  endfunction

  function automatic int ror(input int x);
    return x / 2 + (x % 2) * (NPAT / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p = 0; last_ev = 0; s1 = 0; s2 = 0; m_mode = M_IDLE; run = 0; e_period = 0;
    e_dir = 0; e_shift = 0; e_locked = 0; e_err = 0; e_tmo = 0;
  endtask

  // s1/s2: the two most recent samples of i_led; periods are edge-count differences.
  task automatic model_edge(input int v);
    int cnt;
    bit oh1, oh2, lft, rgt, valid, same;
    p++;
    cnt = p - 1 - last_ev;
    if (cnt > PMAX) cnt = PMAX;
    oh1 = (ones(s1) == 1);
    oh2 = (ones(s2) == 1);
    lft = (s1 == rol(s2));
    rgt = (s1 == ror(s2));
    valid = oh1 && oh2 && (s1 != s2) && (lft || rgt);
    e_shift = 0; e_err = 0; e_tmo = 0;
    if (m_mode == M_IDLE) begin
      if (oh1) m_mode = M_SYNC;
    end else if ((s1 != 0 && !oh1) || (oh1 && oh2 && s1 != s2 && !valid)) begin
      e_err = 1; e_locked = 0; m_mode = M_IDLE;
    end else if (s1 == 0) begin
      e_locked = 0; m_mode = M_IDLE;
    end else if (valid) begin
      e_shift = 1;
      if (m_mode == M_SYNC) begin
        m_mode = M_MEAS; run = 0;
      end else begin
        same = (run > 0) && (cnt == e_period) && (lft == e_dir);
        run = same ? run + 1 : 1;
        e_period = cnt;
        if (m_mode == M_MEAS && run > LOCK_CNT) begin
          m_mode = M_LOCK; e_locked = 1;
        end else if (m_mode == M_LOCK && !same) begin
          m_mode = M_MEAS; e_locked = 0;
        end
      end
      e_dir = lft;
    end else if (TMO_EN && m_mode != M_SYNC && cnt == PMAX) begin
      e_tmo = 1; e_locked = 0; m_mode = M_IDLE;
    end
    if (valid) last_ev = p - 1;
    s2 = s1;
    s1 = v;
  endtask

  task automatic step(input int v, input int n);
    for (int k = 0; k < n; k++) begin
      i_led = N_LEDS'(v);
      @(posedge clock);
      model_edge(v);
      #1;
      chk($sformatf("cycle%0d", p), {o_period, o_dir, o_shift, o_locked, o_err, o_timeout},
          {NB_PERIOD'(e_period), e_dir, e_shift, e_locked, e_err, e_tmo});
      err_seen   += int'(o_err);
      tmo_seen   += int'(o_timeout);
      shift_seen += int'(o_shift);
    end
  endtask

  task automatic rotate_left_lock();
    step(1, 10); step(2, 10); step(4, 10); step(8, 10); step(1, 10); step(2, 10);
  endtask

  initial begin
    int cur, kind, v;
    i_reset = 1'b0;
    i_led   = 4'b0101;
    model_reset();
    #1;
    chk("reset_async", {o_period, o_dir, o_shift, o_locked, o_err, o_timeout}, 0);
    #99;
    chk("reset_held", {o_period, o_dir, o_shift, o_locked, o_err, o_timeout}, 0);
    @(posedge clock); #1;
    i_reset = 1'b1;

    err_seen = 0;
    step(4'b0101, 6);
    chk("illegal_idle_no_err", err_seen, 0);

    shift_seen = 0;
    rotate_left_lock();
    chk("left_shift_count", shift_seen, 5);
    chk("left_locked", o_locked, 1);
    chk("left_period", o_period, 10);
    chk("left_dir", o_dir, 1);

    step(1, 10);
    chk("reverse_dir", o_dir, 0);
    chk("reverse_unlocked", o_locked, 0);
    chk("reverse_period", o_period, 10);

    step(8, 10); step(4, 10); step(2, 10); step(1, 10);
    chk("right_locked", o_locked, 1);

    err_seen = 0;
    step(4'b0011, 4);
    chk("two_hot_err_pulses", err_seen, 1);
    chk("two_hot_unlocked", o_locked, 0);

    step(0, 3); step(1, 5);
    err_seen = 0;
    step(4, 5);
    chk("jump_err_pulses", err_seen, 1);
    step(0, 3); step(1, 5);
    err_seen = 0;
    step(0, 5);
    chk("zero_no_err", err_seen, 0);
    chk("zero_unlocked", o_locked, 0);

    rotate_left_lock();
    chk("pre_freeze_locked", o_locked, 1);
    tmo_seen = 0;
    step(2, 65540);
`ifdef LED_SHIFT_DECODER_TIMEOUT_EN
    chk("freeze_timeout_pulses", tmo_seen, 1);
    chk("freeze_unlocked", o_locked, 0);
`else
    chk("freeze_timeout_pulses", tmo_seen, 0);
    chk("freeze_still_locked", o_locked, 1);
    chk("freeze_period", o_period, 10);
`endif

    // reset in the middle of a measurement
    step(0, 2); step(1, 4); step(2, 4); step(4, 4);
    i_reset = 1'b0;
    #1;
    chk("reset_mid_async", {o_period, o_dir, o_shift, o_locked, o_err, o_timeout}, 0);
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    chk("reset_mid_held", {o_period, o_dir, o_shift, o_locked, o_err, o_timeout}, 0);
    i_reset = 1'b1;
    step(4, 3); step(8, 5);
    chk("post_reset_period", o_period, 0);

    cur = 1;
    for (int seg = 0; seg < 80; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        step(0, $urandom_range(1, 4));
        cur = 1;
      end else if (kind == 1) begin
        do v = $urandom_range(1, NPAT - 1); while (ones(v) < 2);
        step(v, $urandom_range(1, 3));
        cur = 1;
      end else if (kind == 2) begin
        cur = rol(rol(cur));
        step(cur, 3);
      end else begin
        int dir, per, nev;
        dir = $urandom_range(0, 1);
        per = $urandom_range(1, 12);
        nev = $urandom_range(3, 8);
        for (int e = 0; e < nev; e++) begin
          cur = dir ? rol(cur) : ror(cur);
          step(cur, per);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
